// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo
// ------------------------------------------------------------------------
// 8N1 UART receiver with mid-bit sampling, feeding a 16-entry
// first-word-fall-through FIFO. Framing errors and FIFO overruns are
// reported through sticky flags.
//
// Parameters
//   clk_freq         system clock in Hz
//   uart_baud_rate   line bit rate
//   fifo_depth_log2  FIFO depth = 2**fifo_depth_log2
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   uart_rxd   in   serial line, idle high, asynchronous to clk
//   rx_data    out  FIFO head byte (combinational read)
//   rx_avail   out  FIFO not empty
//   rx_pop     in   consume head byte on this edge
//   rx_count   out  bytes held, 0..2**fifo_depth_log2
//   overrun    out  sticky: byte dropped because FIFO was full
//   frame_err  out  sticky: stop bit sampled low
//   err_clr    in   clears both sticky flags (a same-cycle set wins)
//   dbg_state  out  receiver FSM state
//
// Handshake: rx_avail is the valid and rx_pop is the ready of the read
// side. A byte transfers on every rising edge where both are 1; rx_data is
// stable while rx_avail=1 and rx_pop=0. rx_pop with rx_avail=0 is ignored.
// ------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int clk_freq        = 50000000,
  parameter int uart_baud_rate  = 1152000,
  parameter int fifo_depth_log2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rxd,
  output logic [7:0]               rx_data,
  output logic                     rx_avail,
  input  logic                     rx_pop,
  output logic [fifo_depth_log2:0] rx_count,
  output logic                     overrun,
  output logic                     frame_err,
  input  logic                     err_clr,
  output logic [2:0]               dbg_state
);

  // Bit period rounded to nearest clock count, half period floored.
  localparam int D     = (clk_freq + uart_baud_rate / 2) / uart_baud_rate;
  localparam int H     = D / 2;
  localparam int CW    = (D > 2) ? $clog2(D) : 1;
  localparam int AW    = fifo_depth_log2;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] D_M1     = CW'(D - 1);
  localparam logic [CW-1:0] H_M1     = CW'(H - 1);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // ---------------------------------------------------------------------
  // Input synchronizer (both stages reset to the idle level)
  // ---------------------------------------------------------------------
  logic r_sync1;
  logic r_rxd_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  logic w_cnt_zero;
  logic w_stop_sample;
  logic w_push;
  logic w_frame_set;

  assign w_cnt_zero    = (r_cnt == '0);
  assign w_stop_sample = (r_state == S_STOP) && w_cnt_zero;
  // The byte is pushed on the very edge that samples a good stop bit, so
  // the FIFO write and the FSM return to IDLE happen together.
  assign w_push        = w_stop_sample && r_rxd_s;
  assign w_frame_set   = w_stop_sample && !r_rxd_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxd_s) begin
            r_state <= S_START;
            r_cnt   <= H_M1;
          end
        end
        S_START: begin
          if (w_cnt_zero) begin
            // Mid start bit: a line back at 1 was only a glitch.
            if (!r_rxd_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
              r_cnt     <= D_M1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            r_shift <= {r_rxd_s, r_shift[7:1]};  // LSB arrives first
            r_cnt   <= D_M1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_cnt_zero) begin
            r_state <= r_rxd_s ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it cannot look like a new start bit.
          if (r_rxd_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = r_state;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;
  logic w_ovr_set;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = rx_pop && !w_empty;
  // When full, a simultaneous pop frees the head slot, which is exactly
  // the slot the write pointer addresses, so the push can proceed.
  assign w_do_push = w_push && (!w_full || rx_pop);
  assign w_ovr_set = w_push && w_full && !rx_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data  = r_mem[r_rptr];
  assign rx_avail = !w_empty;
  assign rx_count = r_count;

  // ---------------------------------------------------------------------
  // Sticky error flags: a set event beats a same-cycle clear
  // ---------------------------------------------------------------------
  logic r_overrun;
  logic r_frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_ovr_set   || (r_overrun   && !err_clr);
      r_frame_err <= w_frame_set || (r_frame_err && !err_clr);
    end
  end

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int D = 43;
  localparam int H = 21;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic       clk;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_pop;
  logic [4:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       err_clr;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .clk_freq        (50000000),
    .uart_baud_rate  (1152000),
    .fifo_depth_log2 (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_pop    (rx_pop),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog observed=timeout required=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // Checker and driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call 1 ns after an edge; each bit is held exactly D cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rxd = fr[j];
      step(D);
    end
  endtask

  task automatic pop_one();
    rx_pop = 1'b1;
    step(1);
    rx_pop = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_avail"}, 32'(rx_avail), 32'd1);
      chk({tag, "_data"}, 32'(rx_data), 32'(e));
      pop_one();
    end
    chk({tag, "_empty"}, 32'(rx_count), 32'd0);
  endtask

  // Directed sequence
  initial begin
    rst      = 1'b0;
    uart_rxd = 1'b1;
    rx_pop   = 1'b0;
    err_clr  = 1'b0;
    step(3);
    chk("rst_avail", 32'(rx_avail), 32'd0);
    chk("rst_count", 32'(rx_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame", 32'(frame_err), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    step(2);

    // Single byte 0xA5 with exact arrival edge k+410
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (410) @(posedge clk);  // edge k+409
        #1;
        chk("a5_avail_k409", 32'(rx_avail), 32'd0);
        step(1);                      // edge k+410
        chk("a5_avail_k410", 32'(rx_avail), 32'd1);
        chk("a5_count_k410", 32'(rx_count), 32'd1);
      end
    join
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_overrun", 32'(overrun), 32'd0);
    chk("a5_frame", 32'(frame_err), 32'd0);
    pop_one();
    chk("a5_pop_count", 32'(rx_count), 32'd0);
    chk("a5_pop_avail", 32'(rx_avail), 32'd0);

    // 17 back-to-back bytes, last one overruns
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1);
      if (i < 16) exp_q.push_back(8'(i));
    end
    step(2);
    chk("ovr_count", 32'(rx_count), 32'd16);
    chk("ovr_flag", 32'(overrun), 32'd1);
    drain_check("ovr_drain");
    chk("ovr_sticky", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Framing error with err_clr colliding on the set edge, then low hold
    fork
      send_byte(8'h3C, 1'b0);
      begin
        repeat (410) @(posedge clk);  // edge k+409
        #1;
        err_clr = 1'b1;
        step(1);                      // edge k+410: set and clear together
        err_clr = 1'b0;
        chk("fe_set_wins", 32'(frame_err), 32'd1);
      end
    join
    step(3 * D);
    chk("fe_hold_state", 32'(dbg_state), 32'(ST_BREAK));
    chk("fe_hold_count", 32'(rx_count), 32'd0);
    chk("fe_flag", 32'(frame_err), 32'd1);
    uart_rxd = 1'b1;
    step(D);
    chk("fe_idle", 32'(dbg_state), 32'(ST_IDLE));
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    chk("fe_after_count", 32'(rx_count), 32'd2);
    drain_check("fe_drain");
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("fe_clr", 32'(frame_err), 32'd0);

    // 10-cycle glitch is rejected at the start-bit sample
    uart_rxd = 1'b0;
    step(10);                         // edge k+9
    uart_rxd = 1'b1;
    step(13);                         // edge k+22
    chk("gl_start", 32'(dbg_state), 32'(ST_START));
    step(1);                          // edge k+2+H
    chk("gl_idle", 32'(dbg_state), 32'(ST_IDLE));
    step(D);
    chk("gl_count", 32'(rx_count), 32'd0);
    chk("gl_overrun", 32'(overrun), 32'd0);
    chk("gl_frame", 32'(frame_err), 32'd0);

    // Full FIFO: push and pop on the same edge
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h40 + 8'(i), 1'b1);
      exp_q.push_back(8'h40 + 8'(i));
    end
    fork
      send_byte(8'h50, 1'b1);
      begin
        repeat (410) @(posedge clk);  // edge k+409
        #1;
        chk("fp_count_before", 32'(rx_count), 32'd16);
        rx_pop = 1'b1;
        step(1);                      // edge k+410: push + pop
        rx_pop = 1'b0;
        chk("fp_count_after", 32'(rx_count), 32'd16);
        chk("fp_overrun", 32'(overrun), 32'd0);
        chk("fp_head", 32'(rx_data), 32'h41);
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h50);
    drain_check("fp_drain");
    pop_one();
    chk("pe_count", 32'(rx_count), 32'd0);
    chk("pe_avail", 32'(rx_avail), 32'd0);
    chk("pe_overrun", 32'(overrun), 32'd0);

    // Reset during data bit 4 of 0xFF
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (232) @(posedge clk);  // edge k+231, inside data bit 4
        #1;
        chk("rm_in_data", 32'(dbg_state), 32'(ST_DATA));
        rst = 1'b0;
        #2;
        chk("rm_async_state", 32'(dbg_state), 32'(ST_IDLE));
        step(3);
        rst = 1'b1;
      end
    join
    step(2);
    chk("rm_after_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rm_after_count", 32'(rx_count), 32'd0);
    send_byte(8'h5A, 1'b1);
    chk("rm_5a_count", 32'(rx_count), 32'd1);
    chk("rm_5a_data", 32'(rx_data), 32'h5A);
    chk("rm_5a_frame", 32'(frame_err), 32'd0);
    chk("rm_5a_overrun", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end for the sensor-node SoC: consumes the 8N1 stream on a UART line (the `uart_txd`/`uart_txd1` output of `system`, or an external partner driving `uart_rxd`), recovers bytes by mid-bit sampling, and buffers them in a first-word-fall-through FIFO. It is used as a synthesizable loopback/monitor partner in the system bench and as a second-channel receiver in hardware. Framing and overrun conditions are reported through sticky flags.

## Interface
- `clk_freq`, 50000000, system clock frequency in Hz
- `uart_baud_rate`, 1152000, line bit rate
- `fifo_depth_log2`, 4, FIFO depth = 2^fifo_depth_log2 entries (16)

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `uart_rxd`  in  1  serial input, idle high, asynchronous to `clk`
- `rx_data`  out  8  FIFO head byte, valid while `rx_avail`=1
- `rx_avail`  out  1  FIFO not empty
- `rx_pop`  in  1  consume head byte on this edge
- `rx_count`  out  fifo_depth_log2+1  bytes currently held, 0..16
- `overrun`  out  1  sticky: byte dropped because FIFO full
- `frame_err`  out  1  sticky: stop bit sampled low
- `err_clr`  in  1  clears both sticky flags

## Operation
- Input synchronizer: 2 flops, both reset to 1. All decisions use the second stage `rxd_s`.
- Bit period `D = (clk_freq + uart_baud_rate/2) / uart_baud_rate`, integer division. With the defaults, `D = 43`. `H = D/2` (floor), so `H = 21`. The down-counter is wide enough for `D-1`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxd_s`=0 -> START, counter loaded with `H-1`.
  - START: when counter reaches 0, sample. If 0 -> DATA with bit index 0 and counter `D-1`. If 1 -> IDLE (glitch rejected, no flag).
  - DATA: sample every D cycles into a shift register, LSB first. After bit 7 -> STOP with counter `D-1`.
  - STOP: sample. If 1 -> push byte and go to IDLE. If 0 -> set `frame_err`, discard the byte, go to BREAK.
  - BREAK: stay until `rxd_s`=1, then go to IDLE.
- FIFO: 16 x 8 memory with wrapping read/write pointers; `rx_count` is kept explicitly.
  - Push while full, without pop: byte dropped, `overrun` set, contents untouched.
  - Push and `rx_pop` in the same cycle: both execute, including when full or when empty. With pop on empty, the byte is written and the count ends at 1.
  - `rx_pop` on empty without push is ignored.
- `rx_data` is the combinational read of the head entry. Its value is don't-care when `rx_avail`=0.
- Sticky flags:
  - `err_clr` clears both flags.
  - A set event in the same cycle as `err_clr` wins; the flag stays 1.

## Timing
- Reset values:
  - `rx_avail`=0, `rx_count`=0
  - `overrun`=0, `frame_err`=0
  - `rx_data`=0
  - FSM in IDLE, synchronizer at 1, pointers at 0
- Reset mid-frame aborts reception immediately. The partial byte is lost, and the first frame after release needs a fresh falling edge.
- Edge numbering: let edge k be the first edge at which `uart_rxd`=0 is captured into sync stage 1.
  - START entry: edge k+2.
  - Start-bit sample: edge k+2+H.
  - Data bit n sample: edge k+2+H+(n+1)·D.
  - Stop sample and FIFO write: edge k+2+H+9·D.
  - With the defaults, `rx_avail`/`rx_count` update after edge k+410.
- Back-to-back frames: a new start bit is accepted in the cycle after the STOP sample. Line-rate throughput is sustained with no gap.
- `rx_pop` takes effect on its edge. The next byte appears on `rx_data` in the following cycle.
- Tolerable baud mismatch: ±4 % total (mid-bit sampling over 9.5 bits).

## Test plan
- Reset, then send 0xA5 at D=43 -> `rx_avail` rises after edge k+410, `rx_data`=0xA5, `rx_count`=1, both flags 0. Pulse `rx_pop` -> `rx_count`=0, `rx_avail`=0.
- Send 17 bytes 0x00..0x10 with no pop -> `rx_count`=16, `overrun`=1. Pop order is 0x00..0x0F; 0x10 is lost. Pulse `err_clr` -> `overrun`=0.
- Send 0x3C with the stop bit driven 0, holding the line low 3·D more, then two normal bytes 0x11, 0x22:
  - `frame_err`=1 and 0x3C is not stored.
  - No frame starts during the low hold.
  - 0x11 and 0x22 are then received correctly.
- Drive a 10-cycle low glitch -> no push, no flags, FSM back in IDLE by edge k+2+H.
- When `rx_count`=16, push and pop in the same cycle -> count stays 16, `overrun`=0, the oldest byte is removed and the new byte sits at the tail. Separately, pop on empty -> no change.
- Assert `rst`=0 during data bit 4 of 0xFF, release, then send 0x5A -> only 0x5A is received, `rx_count`=1.
